// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter.
// Ports: clk_i/rst_i (sync, active-high), data_i/wr_i push side,
// TXD_o serial line, full_o/empty_o/count_o FIFO status,
// busy_o frame in progress, ovf_o one-cycle dropped-write pulse.
module uart_tx_fifo #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [7:0]               data_i,
    input  logic                     wr_i,
    output logic                     TXD_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     busy_o,
    output logic                     ovf_o
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [AW:0]   COUNT_MAX = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [BW-1:0]   baud_q;
    logic [BW-1:0]   baud_d;
    logic [2:0]      bit_q;
    logic [2:0]      bit_d;
    logic [7:0]      shift_q;
    logic [7:0]      shift_d;

    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            ovf_q;

    logic            push;
    logic            pop;
    logic            bit_end;

    // Status comes from registered count only, so wr_i never
    // reaches full_o/empty_o combinationally.
    assign full_o  = (count_q == COUNT_MAX);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign busy_o  = (state_q != IDLE);
    assign ovf_o   = ovf_q;

    // A write seen while full is dropped even if a pop frees a slot
    // at the same edge.
    assign push    = wr_i && !full_o;
    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        TXD_o = 1'b1;
        unique case (state_q)
            START:   TXD_o = 1'b0;
            DATA:    TXD_o = shift_q[0];
            default: TXD_o = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!empty_o) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b1, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= wr_i && full_o;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized scenarios against a queue model,
// with a line decoder rebuilding bytes from TXD_o.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int DEPTH    = 16;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr  = 1'b0;
    logic [7:0] din = 8'h00;
    logic       txd;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       busy;
    logic       ovf;

    uart_tx_fifo #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (din),
        .wr_i   (wr),
        .TXD_o  (txd),
        .full_o (full),
        .empty_o(empty),
        .count_o(count),
        .busy_o (busy),
        .ovf_o  (ovf)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [7:0] rx_q[$];
    bit         rx_ok_q[$];
    int         rx_t_q[$];
    logic [7:0] exp_q[$];

    bit         mon_active = 0;
    bit         mon_ok;
    int         mon_cnt;
    int         mon_k;
    int         mon_t;
    logic [7:0] mon_byte;

    // Line decoder: finds a start bit, samples mid-bit, records
    // the byte, framing status and cycle of the start bit.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mon_active = 0;
        end else if (!mon_active) begin
            if (txd === 1'b0) begin
                mon_active = 1;
                mon_cnt    = 0;
                mon_ok     = 1;
                mon_t      = cyc;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % DIV == DIV / 2) begin
                mon_k = mon_cnt / DIV;
                if (mon_k == 0) begin
                    mon_ok = mon_ok && (txd === 1'b0);
                end else if (mon_k <= 8) begin
                    mon_byte[mon_k-1] = txd;
                end else begin
                    mon_ok = mon_ok && (txd === 1'b1);
                    rx_q.push_back(mon_byte);
                    rx_ok_q.push_back(mon_ok);
                    rx_t_q.push_back(mon_t);
                    mon_active = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(input int n, output bit ok);
        int lim;
        int c;
        lim = n * (FRAME + 1) + 4 * FRAME;
        c   = 0;
        while (rx_q.size() < n && c < lim) begin
            tick();
            c++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr  = 1'b1;
        din = 8'($urandom);
        tick();
        tick();
        total++;
        if (txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd);
        else passed++;
        total++;
        if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count);
        else passed++;
        total++;
        if ({empty, full, busy, ovf} !== 4'b1000)
            $display("FAIL reset_flags: got %b want 1000", {empty, full, busy, ovf});
        else passed++;
        wr  = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        bit ok;
        logic [7:0] g;
        bit gok;
        din = 8'h3D;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
        din = 8'($urandom);
        total++;
        if ({count, txd, empty} !== {5'd1, 1'b1, 1'b0})
            $display("FAIL single_queued: got cnt=%0d txd=%b empty=%b want 1 1 0", count, txd, empty);
        else passed++;
        tick();
        total++;
        if ({txd, busy, count} !== {1'b0, 1'b1, 5'd0})
            $display("FAIL single_start: got txd=%b busy=%b cnt=%0d want 0 1 0", txd, busy, count);
        else passed++;
        n = 0;
        while (busy && n < FRAME + 10) begin
            tick();
            n++;
        end
        total++;
        if (n != FRAME) $display("FAIL single_busy_len: got %0d want %0d", n, FRAME);
        else passed++;
        wait_rx(1, ok);
        total++;
        if (!ok) begin
            $display("FAIL single_rx: got %0d frames want 1", rx_q.size());
            rx_q.delete(); rx_ok_q.delete(); rx_t_q.delete();
        end else begin
            g   = rx_q.pop_front();
            gok = rx_ok_q.pop_front();
            void'(rx_t_q.pop_front());
            if (g !== 8'h3D || !gok)
                $display("FAIL single_rx: got %h ok=%0d want 3d", g, gok);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int t0;
        int t1;
        logic [7:0] g;
        bit gok;
        exp_q.push_back(8'h3D);
        exp_q.push_back(8'h02);
        din = 8'h3D;
        wr  = 1'b1;
        tick();
        total++;
        if (count !== 5'd1) $display("FAIL b2b_count1: got %0d want 1", count);
        else passed++;
        din = 8'h02;
        tick();
        wr  = 1'b0;
        din = 8'($urandom);
        total++;
        if (count !== 5'd1) $display("FAIL b2b_count2: got %0d want 1", count);
        else passed++;
        wait_rx(2, ok);
        total++;
        if (!ok) begin
            $display("FAIL b2b_rx: got %0d frames want 2", rx_q.size());
            rx_q.delete(); rx_ok_q.delete(); rx_t_q.delete(); exp_q.delete();
        end else begin
            passed++;
            t0 = rx_t_q[0];
            t1 = rx_t_q[1];
            total++;
            if (t1 - t0 != FRAME + 1)
                $display("FAIL b2b_pitch: got %0d want %0d", t1 - t0, FRAME + 1);
            else passed++;
            for (int i = 0; i < 2; i++) begin
                g   = rx_q.pop_front();
                gok = rx_ok_q.pop_front();
                void'(rx_t_q.pop_front());
                total++;
                if (g !== exp_q[0] || !gok)
                    $display("FAIL b2b_byte[%0d]: got %h ok=%0d want %h", i, g, gok, exp_q[0]);
                else passed++;
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [7:0] g;
        bit gok;
        logic [7:0] first;
        first = 8'($urandom);
        exp_q.push_back(first);
        din = first;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) begin
            din = 8'(i);
            wr  = 1'b1;
            tick();
            if (i < 16) exp_q.push_back(8'(i));
            if (i == 15) begin
                total++;
                if ({full, ovf, count} !== {1'b1, 1'b0, 5'd16})
                    $display("FAIL ovf_full: got full=%b ovf=%b cnt=%0d want 1 0 16", full, ovf, count);
                else passed++;
            end
        end
        wr  = 1'b0;
        din = 8'hFF;
        total++;
        if ({full, ovf, count} !== {1'b1, 1'b1, 5'd16})
            $display("FAIL ovf_pulse: got full=%b ovf=%b cnt=%0d want 1 1 16", full, ovf, count);
        else passed++;
        tick();
        total++;
        if (ovf !== 1'b0) $display("FAIL ovf_one_cycle: got %b want 0", ovf);
        else passed++;
        wait_rx(17, ok);
        total++;
        if (!ok) begin
            $display("FAIL ovf_rx: got %0d frames want 17", rx_q.size());
            rx_q.delete(); rx_ok_q.delete(); rx_t_q.delete(); exp_q.delete();
        end else begin
            passed++;
            for (int i = 0; i < 17; i++) begin
                g   = rx_q.pop_front();
                gok = rx_ok_q.pop_front();
                void'(rx_t_q.pop_front());
                total++;
                if (g !== exp_q[0] || !gok)
                    $display("FAIL ovf_byte[%0d]: got %h ok=%0d want %h", i, g, gok, exp_q[0]);
                else passed++;
                void'(exp_q.pop_front());
            end
        end
        repeat (FRAME + 20) tick();
        total++;
        if (rx_q.size() != 0 || empty !== 1'b1)
            $display("FAIL ovf_extra: got %0d extra frames empty=%b want 0 1", rx_q.size(), empty);
        else passed++;
    endtask

    task automatic test_simul();
        bit ok;
        int n;
        logic [7:0] g;
        bit gok;
        logic [7:0] b;
        for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom));
        b   = exp_q[2];
        din = exp_q[0];
        wr  = 1'b1;
        tick();
        din = exp_q[1];
        tick();
        wr  = 1'b0;
        n   = 0;
        while (busy && n < FRAME + 10) begin
            tick();
            n++;
        end
        total++;
        if ({busy, count} !== {1'b0, 5'd1})
            $display("FAIL simul_idle: got busy=%b cnt=%0d want 0 1", busy, count);
        else passed++;
        din = b;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
        total++;
        if ({busy, count} !== {1'b1, 5'd1})
            $display("FAIL simul_pushpop: got busy=%b cnt=%0d want 1 1", busy, count);
        else passed++;
        wait_rx(3, ok);
        total++;
        if (!ok) begin
            $display("FAIL simul_rx: got %0d frames want 3", rx_q.size());
            rx_q.delete(); rx_ok_q.delete(); rx_t_q.delete(); exp_q.delete();
        end else begin
            passed++;
            for (int i = 0; i < 3; i++) begin
                g   = rx_q.pop_front();
                gok = rx_ok_q.pop_front();
                void'(rx_t_q.pop_front());
                total++;
                if (g !== exp_q[0] || !gok)
                    $display("FAIL simul_byte[%0d]: got %h ok=%0d want %h", i, g, gok, exp_q[0]);
                else passed++;
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] g;
        bit gok;
        logic [7:0] y;
        din = 8'hA5;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            din = 8'($urandom);
            wr  = 1'b1;
            tick();
        end
        wr = 1'b0;
        repeat (4 * DIV + DIV / 2 - 3) tick();
        rst = 1'b1;
        wr  = 1'b1;
        din = 8'($urandom);
        tick();
        total++;
        if ({txd, count, empty, busy, full, ovf} !== {1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL rstmid_state: got txd=%b cnt=%0d empty=%b busy=%b want 1 0 1 0",
                     txd, count, empty, busy);
        else passed++;
        rst = 1'b0;
        wr  = 1'b0;
        repeat (3 * (FRAME + 1) + 20) tick();
        total++;
        if (rx_q.size() != 0 || busy !== 1'b0)
            $display("FAIL rstmid_silent: got %0d frames busy=%b want 0 0", rx_q.size(), busy);
        else passed++;
        rx_q.delete(); rx_ok_q.delete(); rx_t_q.delete();
        rst = 1'b1;
        tick();
        y   = 8'($urandom);
        rst = 1'b0;
        wr  = 1'b1;
        din = y;
        tick();
        wr  = 1'b0;
        total++;
        if (count !== 5'd1) $display("FAIL rst_first_write: got %0d want 1", count);
        else passed++;
        wait_rx(1, ok);
        total++;
        if (!ok) begin
            $display("FAIL rst_first_rx: got %0d frames want 1", rx_q.size());
            rx_q.delete(); rx_ok_q.delete(); rx_t_q.delete();
        end else begin
            g   = rx_q.pop_front();
            gok = rx_ok_q.pop_front();
            void'(rx_t_q.pop_front());
            if (g !== y || !gok)
                $display("FAIL rst_first_rx: got %h ok=%0d want %h", g, gok, y);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [7:0] g;
        bit gok;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) begin
                din = 8'(b * 10 + i);
                exp_q.push_back(din);
                wr  = 1'b1;
                tick();
            end
            wr = 1'b0;
            wait_rx(10, ok);
            total++;
            if (!ok) begin
                $display("FAIL wrap_rx[%0d]: got %0d frames want 10", b, rx_q.size());
                rx_q.delete(); rx_ok_q.delete(); rx_t_q.delete(); exp_q.delete();
            end else begin
                passed++;
                for (int i = 0; i < 10; i++) begin
                    g   = rx_q.pop_front();
                    gok = rx_ok_q.pop_front();
                    void'(rx_t_q.pop_front());
                    total++;
                    if (g !== exp_q[0] || !gok)
                        $display("FAIL wrap_byte[%0d]: got %h ok=%0d want %h",
                                 b * 10 + i, g, gok, exp_q[0]);
                    else passed++;
                    void'(exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int len;
        logic [7:0] g;
        bit gok;
        for (int b = 0; b < 5; b++) begin
            len = $urandom_range(1, 15);
            for (int i = 0; i < len; i++) begin
                wr = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
                din = 8'($urandom);
                exp_q.push_back(din);
                wr  = 1'b1;
                tick();
                wr  = 1'b0;
                din = 8'($urandom);
            end
            wait_rx(len, ok);
            total++;
            if (!ok) begin
                $display("FAIL rand_rx[%0d]: got %0d frames want %0d", b, rx_q.size(), len);
                rx_q.delete(); rx_ok_q.delete(); rx_t_q.delete(); exp_q.delete();
            end else begin
                passed++;
                for (int i = 0; i < len; i++) begin
                    g   = rx_q.pop_front();
                    gok = rx_ok_q.pop_front();
                    void'(rx_t_q.pop_front());
                    total++;
                    if (g !== exp_q[0] || !gok)
                        $display("FAIL rand_byte[%0d.%0d]: got %h ok=%0d want %h",
                                 b, i, g, gok, exp_q[0]);
                    else passed++;
                    void'(exp_q.pop_front());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_simul();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate.
REQ-003 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, ≥2.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port data_i  input  8  byte to queue.
REQ-007 SHALL have port wr_i  input  1  push strobe; one byte per cycle high.
REQ-008 SHALL have port TXD_o  output  1  serial line, idle high.
REQ-009 SHALL have port full_o  output  1  FIFO holds DEPTH bytes.
REQ-010 SHALL have port empty_o  output  1  FIFO holds 0 bytes.
REQ-011 SHALL have port count_o  output  log2(DEPTH)+1  bytes queued, excluding the byte in transmission.
REQ-012 SHALL have port busy_o  output  1  frame in progress (state ≠ IDLE).
REQ-013 SHALL have port ovf_o  output  1  one-cycle pulse: write dropped.

Function
REQ-014 SHALL compute bit period DIV = CLK_FREQ/BAUD, integer truncation (10416 cycles at defaults).
REQ-015 SHALL transmit 8N1 frames: start bit 0, data bits LSB first, one stop bit 1; each bit exactly DIV cycles.
REQ-016 SHALL use states IDLE, START, DATA, STOP; bit counter 0..7 in DATA; baud counter 0..DIV-1, cleared on each state entry and bit advance.
REQ-017 IDLE: TXD_o=1; if FIFO non-empty at an edge, SHALL pop head into shift register, enter START, drive TXD_o=0 from that edge.
REQ-018 START -> DATA after DIV cycles; DATA -> STOP after 8th bit's DIV cycles; STOP -> IDLE after DIV cycles.
REQ-019 Back-to-back bytes SHALL be separated by exactly one IDLE cycle (frame pitch 10*DIV+1 cycles).
REQ-020 Write with wr_i=1 and full_o=0 SHALL store data_i at tail; count_o increments at that edge.
REQ-021 Write with full_o=1 SHALL be dropped, FIFO unchanged, ovf_o=1 for the following cycle, even if a pop occurs the same edge.
REQ-022 Simultaneous write (not full) and pop SHALL leave count_o unchanged and keep both bytes in order.
REQ-023 Write into empty FIFO while IDLE: TXD_o SHALL fall one cycle after the write edge.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; full_o/empty_o derived from count_o, registered, no combinational path from wr_i.
REQ-025 data_i SHALL be sampled only at the write edge; later changes do not affect queued bytes.

Reset
REQ-026 rst_i=1 at an edge SHALL force: state IDLE, TXD_o=1, count_o=0, empty_o=1, full_o=0, busy_o=0, ovf_o=0, pointers and counters 0.
REQ-027 Reset mid-frame SHALL abort the frame immediately (TXD_o=1 next edge) and discard all queued bytes; wr_i ignored while rst_i=1.
REQ-028 First write SHALL be accepted at the first edge with rst_i=0.

Verification
REQ-029 Single byte: write 0x3D while idle -> TXD_o low 1 cycle after write, line bits 0,1,0,1,1,1,1,0,0,1 each 10416 cycles, busy_o low after 104160 cycles.
REQ-030 Back-to-back: write 0x3D then 0x02 on consecutive cycles -> count_o 1 then 1 (pop), frames in order, second start bit exactly 104161 cycles after first.
REQ-031 Overflow: with frame active, write 17 bytes 0x00..0x10 consecutively -> full_o after 16th, 17th dropped, ovf_o one pulse, 0x10 never transmitted.
REQ-032 Simultaneous push/pop at count_o=1 in IDLE -> count_o stays 1, both bytes sent in write order.
REQ-033 Reset mid-frame: assert rst_i during DATA bit 3 of 0xA5 with 3 bytes queued -> TXD_o=1, count_o=0, empty_o=1 next cycle; no further frames.
REQ-034 Wrap-around: push/transmit 40 bytes 0x00..0x27 in bursts of 10 -> all 40 received in order by a checker decoding TXD_o.
